muldiv_seq: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the execute stage, accepts MULT/MULTU/DIV/DIVU on a single-cycle start, and computes one shift-add or shift-subtract step per cycle. It exposes HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes. While an operation is in flight it drives a stall request to the hazard unit.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV support).
package muldiv_pkg;

    // One shift-add or shift-subtract step per operand bit.
    localparam int MULDIV_ITERS = 32;

    // Encodings match the 2-bit op port driven by the decoder.
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Magnitude of a two's-complement value when en is set, else pass-through.
    // -2^31 maps to 32'h80000000, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: {acc, multiplier} pair, add multiplicand on LSB, shift right.
// Divide:   {rem, quotient} pair, shift left, restoring subtract of divisor.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [63:0] i_pair,
    input  logic [31:0] i_opnd,
    input  logic        i_is_div,
    output logic [63:0] o_pair
);

    logic [32:0] w_add;
    logic [32:0] w_rem_sh;
    logic        w_fits;
    logic [31:0] w_sub;

    // Compute both candidate next pairs and select by operation type.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        o_pair   = i_pair;
        w_add    = i_pair[0] ? ({1'b0, i_pair[63:32]} + {1'b0, i_opnd})
                             : {1'b0, i_pair[63:32]};
        // Remainder after shifting in the next dividend bit; may need 33 bits.
        w_rem_sh = i_pair[63:31];
        w_fits   = (w_rem_sh >= {1'b0, i_opnd});
        // When the divisor fits, rem_sh < 2*divisor, so the difference fits in 32 bits.
        w_sub    = w_rem_sh[31:0] - i_opnd;
        if (i_is_div) begin
            o_pair = w_fits ? {w_sub, i_pair[30:0], 1'b1}
                            : {w_rem_sh[31:0], i_pair[30:0], 1'b0};
        end else begin
            o_pair = {w_add, i_pair[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Latency is 33 cycles from start: 32 iterations plus one sign-fix cycle.
// Optional feature macro: MULDIV_SIGNED_EN (when undefined all ops are unsigned).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    muldiv_state_t r_state;
    logic [4:0]    r_cnt;
    logic [63:0]   r_pair;
    logic [31:0]   r_opnd;
    logic          r_is_div;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    muldiv_op_t    w_op;
    logic          w_is_div;
    logic          w_signed;
    logic [31:0]   w_a_abs;
    logic [31:0]   w_b_abs;
    logic [63:0]   w_next_pair;
    logic          w_neg_q;
    logic          w_neg_r;
    logic [63:0]   w_prod;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;
    logic          w_hi_en;
    logic          w_lo_en;
    logic [31:0]   w_hi_d;
    logic [31:0]   w_lo_d;

    assign w_op     = muldiv_op_t'(op);
    assign w_is_div = (w_op == DIV) || (w_op == DIVU);

`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_signed = (w_op == MULT) || (w_op == DIV);
    assign w_neg_q  = r_neg_q;
    assign w_neg_r  = r_neg_r;

    // Remember result sign: quotient/product negate on differing signs, remainder follows dividend.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_neg_q <= w_signed & (a[31] ^ b[31]);
            r_neg_r <= w_signed & a[31];
        end
    end
`else
    assign w_signed = 1'b0;
    assign w_neg_q  = 1'b0;
    assign w_neg_r  = 1'b0;
`endif

    assign w_a_abs = abs32(a, w_signed);
    assign w_b_abs = abs32(b, w_signed);

    muldiv_step u_step (
        .i_pair   (r_pair),
        .i_opnd   (r_opnd),
        .i_is_div (r_is_div),
        .o_pair   (w_next_pair)
    );

    // Control FSM and iteration datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the datapath registers are reset too, so a mid-operation abort leaves no stale state.
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_pair   <= 64'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= BUSY;
                        r_busy   <= 1'b1;
                        r_cnt    <= 5'd0;
                        r_is_div <= w_is_div;
                        // Divide iterates on the dividend, multiply on the multiplier.
                        r_pair   <= {32'd0, (w_is_div ? w_a_abs : w_b_abs)};
                        r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                    end
                end
                BUSY: begin
                    r_pair <= w_next_pair;
                    if (r_cnt == 5'(MULDIV_ITERS - 1)) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sign-corrected results and the next HI/LO values.
    always_comb begin
        w_prod  = w_neg_q ? (64'd0 - r_pair) : r_pair;
        w_quot  = w_neg_q ? (32'd0 - r_pair[31:0]) : r_pair[31:0];
        w_rem   = w_neg_r ? (32'd0 - r_pair[63:32]) : r_pair[63:32];
        w_hi_en = 1'b0;
        w_lo_en = 1'b0;
        w_hi_d  = wdata;
        w_lo_d  = wdata;
        if (r_state == IDLE && !start) begin
            // A start in the same cycle drops the MT write.
            w_hi_en = mthi;
            w_lo_en = mtlo;
        end else if (r_state == FIX) begin
            w_hi_en = 1'b1;
            w_lo_en = 1'b1;
            if (r_is_div) begin
                // The unsigned loop leaves |a| as remainder on a zero divisor, so
                // sign correction restores a; only LO needs the all-ones override.
                w_hi_d = w_rem;
                w_lo_d = (r_opnd == 32'd0) ? 32'hFFFF_FFFF : w_quot;
            end else begin
                w_hi_d = w_prod[63:32];
                w_lo_d = w_prod[31:0];
            end
        end
    end

    // HI enable flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= 32'd0;
        end else if (w_hi_en) begin
            r_hi <= w_hi_d;
        end
    end

    // LO enable flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo <= 32'd0;
        end else if (w_lo_en) begin
            r_lo <= w_lo_d;
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign done  = r_done;
    assign stall = r_busy & (start | rd_hilo | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a vector table of complete operations plus
// hand-written sequences for MT writes, stall/restart and mid-operation reset.
// Expected values follow the MULDIV_SIGNED_EN setting of the build.
module tb_muldiv_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .rd_hilo (rd_hilo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Wait at negedges for done, bounded; returns the busy-high cycle count.
    task automatic wait_done(input string nm, output int bcnt);
        int cyc;
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({nm, "_done"}, {31'd0, done}, 32'd1);
    endtask

    // Issue one start and return at the negedge where done is high.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] va,
                          input logic [31:0] vb, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, bcnt);
    endtask

    initial begin
        int bc;
        int stall_cnt;
        int done_cnt;

        vecs[0]  = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{"divu_by0",    2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[6]  = '{"div_by0_neg", 2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[7]  = '{"divu_100_7",  2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[9]  = '{"mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{"multu_2p16",  2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{"divu_max_1",  2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
`ifdef MULDIV_SIGNED_EN
        vecs[1]  = '{"mult_n3x7",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{"mult_m1x2",   2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5]  = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[8]  = '{"div_7_m2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
`else
        vecs[1]  = '{"mult_n3x7",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB};
        vecs[2]  = '{"mult_m1x2",   2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[3]  = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[5]  = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[8]  = '{"div_7_m2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000};
`endif

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = 32'd0;
        b       = 32'd0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        wdata   = 32'd0;
        rd_hilo = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi",    hi, 32'd0);
        check("rst_lo",    lo, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset_n = 1'b1;

        // MTHI / MTLO in IDLE, visible after one edge.
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'd0);
        mtlo  = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h0BAD_F00D);
        check("mtlo_hi", hi, 32'h1234_5678);

        // Start and MTLO together: start wins, LO untouched until FIX.
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
        check("startmt_busy", {31'd0, busy}, 32'd1);
        check("startmt_lo0",  lo, 32'h0BAD_F00D);
        repeat (20) @(negedge clk);
        check("startmt_lo20", lo, 32'h0BAD_F00D);
        wait_done("startmt", bc);
        check("startmt_lo", lo, 32'h0000_000F);
        check("startmt_hi", hi, 32'd0);

        // Table of complete operations.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, bc);
            check({vecs[i].name, "_busycyc"}, bc, 32'd33);
            check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            @(negedge clk);
            check({vecs[i].name, "_donefall"}, {31'd0, done}, 32'd0);
        end

        // Stall with rd_hilo and a second start held during BUSY; restart in done cycle.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        op        = 2'b01;
        a         = 32'd3;
        b         = 32'd5;
        rd_hilo   = 1'b1;
        stall_cnt = 0;
        for (int c = 0; c < 40 && done !== 1'b1; c++) begin
            if (busy === 1'b1 && stall === 1'b1) stall_cnt++;
            @(negedge clk);
        end
        check("stall_cycles", stall_cnt, 32'd33);
        check("stall_done",   {31'd0, done}, 32'd1);
        check("stall_hi",     hi, 32'd2);
        check("stall_lo",     lo, 32'hE);
        check("stall_off",    {31'd0, stall}, 32'd0);
        @(negedge clk);
        start   = 1'b0;
        rd_hilo = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_done("restart", bc);
        check("restart_lo", lo, 32'h0000_000F);
        check("restart_hi", hi, 32'd0);

        // Reset in the middle of a DIVU aborts with no result.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'hFFFF_FFFF;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_hi",   hi, 32'd0);
        check("abort_lo",   lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort_nodone", done_cnt, 32'd0);
        run_op("post_abort", 2'b01, 32'd3, 32'd5, bc);
        check("post_abort_lo", lo, 32'h0000_000F);
        check("post_abort_hi", hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
